// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: key/tick inputs and mode, adjust and blink outputs of the front-panel controller
interface clock_mode_ctrl_if;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_sel;
    logic       key_inc;
    logic [1:0] mode;
    logic       field_sel;
    logic       run_en;
    logic       inc_min;
    logic       inc_hour;
    logic       sw_toggle;
    logic       sw_clear;
    logic       blink;
    modport master (
        output tick_1hz, key_mode, key_sel, key_inc,
        input  mode, field_sel, run_en, inc_min, inc_hour, sw_toggle, sw_clear, blink
    );
    modport slave (
        input  tick_1hz, key_mode, key_sel, key_inc,
        output mode, field_sel, run_en, inc_min, inc_hour, sw_toggle, sw_clear, blink
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: debounced front-panel keys driving RUN/SET/STOPWATCH mode, adjust and stopwatch pulses
module clock_mode_ctrl #(
    parameter int DEB_CYCLES = 20000,
    parameter int RPT_DELAY  = 10000000,
    parameter int RPT_RATE   = 2000000,
    parameter int TIMEOUT_S  = 30
) (
    input  logic             clk,
    input  logic             rst,
    clock_mode_ctrl_if.slave bus
);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int RMAX = RPT_DELAY > RPT_RATE ? RPT_DELAY : RPT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET = 2'd1, SW = 2'd2} mode_t;

    logic [2:0]    keys, s1, s2, deb, deb_d, ev;
    logic [DW-1:0] dcnt [3];

    assign keys = {bus.key_inc, bus.key_sel, bus.key_mode};

    // Bit 0 mode, bit 1 sel, bit 2 inc; ev is registered so raw-to-event is DEB_CYCLES+3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_d <= '0;
            ev    <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            s1    <= keys;
            s2    <= s1;
            deb_d <= deb;
            ev    <= deb & ~deb_d;
            for (int i = 0; i < 3; i++)
                if (s2[i] == deb[i]) dcnt[i] <= '0;
                else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else dcnt[i] <= dcnt[i] + 1'b1;
        end
    end

    mode_t         state, state_n;
    logic          field, field_n, blink, blink_n, run_en;
    logic [3:0]    pls, pls_n;
    logic [TW-1:0] idle, idle_n;
    logic          rpt_on, rpt_on_n, rpt_first, rpt_first_n, fire;
    logic [RW-1:0] rpt_cnt, rpt_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            field     <= 1'b0;
            blink     <= 1'b1;
            run_en    <= 1'b1;
            pls       <= '0;
            idle      <= '0;
            rpt_on    <= 1'b0;
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else begin
            state     <= state_n;
            field     <= field_n;
            blink     <= blink_n;
            run_en    <= state_n != SET;
            pls       <= pls_n;
            idle      <= idle_n;
            rpt_on    <= rpt_on_n;
            rpt_first <= rpt_first_n;
            rpt_cnt   <= rpt_cnt_n;
        end
    end

    // rpt_cnt counts cycles since the last inc pulse; first gap is RPT_DELAY, later ones RPT_RATE
    always_comb begin
        fire        = rpt_on && deb[2] && rpt_cnt == (rpt_first ? RW'(RPT_DELAY) : RW'(RPT_RATE));
        state_n     = state;
        field_n     = field;
        blink_n     = blink;
        idle_n      = idle;
        rpt_on_n    = rpt_on;
        rpt_first_n = rpt_first;
        rpt_cnt_n   = rpt_cnt;
        pls_n       = '0;
        case (state)
            RUN: if (ev[0]) begin
                state_n   = SET;
                field_n   = 1'b0;
                blink_n   = 1'b1;
                idle_n    = '0;
                rpt_on_n  = 1'b0;
                rpt_cnt_n = '0;
            end
            SET: begin
                blink_n   = blink ^ bus.tick_1hz;
                idle_n    = idle + TW'(bus.tick_1hz);
                rpt_cnt_n = rpt_cnt + 1'b1;
                rpt_on_n  = rpt_on & deb[2];
                if (ev[0]) begin
                    state_n  = SW;
                    rpt_on_n = 1'b0;
                end else if (ev[1]) begin
                    field_n  = ~field;
                    rpt_on_n = 1'b0;
                    idle_n   = '0;
                end else if (ev[2] || fire) begin
                    pls_n       = field ? 4'b0010 : 4'b0001;
                    rpt_on_n    = 1'b1;
                    rpt_first_n = ev[2];
                    rpt_cnt_n   = RW'(1);
                    idle_n      = '0;
                end else if (bus.tick_1hz && idle == TW'(TIMEOUT_S - 1)) state_n = RUN;
            end
            SW: if (ev[0]) state_n = RUN;
                else pls_n = {ev[1], ev[2] & ~ev[1], 2'b00};
            default: state_n = RUN;
        endcase
        blink_n = (state_n == SET) ? blink_n : 1'b1;
    end

    assign bus.mode      = state;
    assign bus.field_sel = field;
    assign bus.run_en    = run_en;
    assign bus.blink     = blink;
    assign {bus.sw_clear, bus.sw_toggle, bus.inc_hour, bus.inc_min} = pls;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: vector table, corner sequences and randomized run against a behavioural model
module tb_clock_mode_ctrl;
    localparam int DEB = 4, RD = 20, RR = 5, TO = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_mode_ctrl_if bus();
    clock_mode_ctrl #(.DEB_CYCLES(DEB), .RPT_DELAY(RD), .RPT_RATE(RR), .TIMEOUT_S(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int c_min, c_hour, c_tog, c_clr, viol_run = 0, viol_pls = 0;
    int hour_q[$];
    logic [3:0] prev_pls = '0;
    logic chk_en = 1'b0;

    // Reference model: debounce as a window over the raw history, repeat as arithmetic on press age
    int md, since, idle;
    logic fs, bl;
    logic [3:0] m_pls;
    logic [2:0] mdeb, rose_d1, rose_d2;
    logic [DEB+1:0] hist [3];

    task automatic mdl_reset();
        md = 0; since = -1; idle = 0; fs = 1'b0; bl = 1'b1; m_pls = '0;
        mdeb = '0; rose_d1 = '0; rose_d2 = '0;
        for (int k = 0; k < 3; k++) hist[k] = '0;
    endtask

    task automatic mdl_step();
        logic [2:0] raw, ev, rose;
        logic lvl, tick, fire;
        raw = {bus.key_inc, bus.key_sel, bus.key_mode};
        tick = bus.tick_1hz;
        ev = rose_d2;
        lvl = mdeb[2];
        rose = '0;
        for (int k = 0; k < 3; k++) begin
            hist[k] = {hist[k][DEB:0], raw[k]};
            if (hist[k][DEB+1:2] == {DEB{~mdeb[k]}}) begin
                mdeb[k] = ~mdeb[k];
                rose[k] = mdeb[k];
            end
        end
        rose_d2 = rose_d1;
        rose_d1 = rose;
        m_pls = '0;
        if (md == 0) begin
            if (ev[0]) begin md = 1; fs = 1'b0; bl = 1'b1; idle = 0; since = -1; end
        end else if (md == 1) begin
            bl = bl ^ tick;
            since = (lvl && since >= 0) ? since + 1 : -1;
            fire = since >= RD && (since - RD) % RR == 0;
            if (ev[0]) begin md = 2; since = -1; end
            else if (ev[1]) begin fs = ~fs; since = -1; idle = 0; end
            else if (ev[2] || fire) begin
                m_pls = fs ? 4'b0010 : 4'b0001;
                if (ev[2]) since = 0;
                idle = 0;
            end else if (tick) begin
                idle++;
                if (idle == TO) md = 0;
            end
        end else begin
            if (ev[0]) md = 0;
            else if (ev[1]) m_pls = 4'b1000;
            else if (ev[2]) m_pls = 4'b0100;
        end
        if (md != 1) bl = 1'b1;
    endtask

    initial begin
        mdl_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) mdl_reset();
            else mdl_step();
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sample();
        logic [3:0] p;
        @(negedge clk);
        p = {bus.sw_clear, bus.sw_toggle, bus.inc_hour, bus.inc_min};
        c_min += int'(bus.inc_min);
        c_hour += int'(bus.inc_hour);
        c_tog += int'(bus.sw_toggle);
        c_clr += int'(bus.sw_clear);
        if (bus.inc_hour) hour_q.push_back(cyc);
        if (bus.run_en !== (bus.mode != 2'd1)) viol_run++;
        if ((p & prev_pls) != 0) viol_pls++;
        prev_pls = p;
        if (chk_en)
            check($sformatf("model@%0d", cyc),
                  32'({bus.mode, bus.field_sel, bus.run_en, p, bus.blink}),
                  32'({2'(md), fs, md != 1, m_pls, bl}));
    endtask

    task automatic step();
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic zero_counts();
        c_min = 0; c_hour = 0; c_tog = 0; c_clr = 0;
        hour_q.delete();
    endtask

    task automatic set_key(input int k, input logic v);
        if (k == 0) bus.key_mode = v;
        else if (k == 1) bus.key_sel = v;
        else bus.key_inc = v;
    endtask

    task automatic press(input int k);
        set_key(k, 1'b1);
        repeat (12) step();
        set_key(k, 1'b0);
        repeat (12) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".mode"}, 32'(bus.mode), 0);
        check({tag, ".field"}, 32'(bus.field_sel), 0);
        check({tag, ".run_en"}, 32'(bus.run_en), 1);
        check({tag, ".blink"}, 32'(bus.blink), 1);
        check({tag, ".pulses"}, 32'({bus.sw_clear, bus.sw_toggle, bus.inc_hour, bus.inc_min}), 0);
    endtask

    typedef struct {
        int   key;
        int   mode;
        logic field;
        logic run_en;
        int   n_min, n_hour, n_tog, n_clr;
    } vec_t;

    vec_t tbl [13];
    int c0, cd [3];
    logic [2:0] rk;

    initial begin
        tbl = '{
            '{1, 0, 1'b0, 1'b1, 0, 0, 0, 0},
            '{2, 0, 1'b0, 1'b1, 0, 0, 0, 0},
            '{0, 1, 1'b0, 1'b0, 0, 0, 0, 0},
            '{1, 1, 1'b1, 1'b0, 0, 0, 0, 0},
            '{1, 1, 1'b0, 1'b0, 0, 0, 0, 0},
            '{2, 1, 1'b0, 1'b0, 1, 0, 0, 0},
            '{1, 1, 1'b1, 1'b0, 0, 0, 0, 0},
            '{2, 1, 1'b1, 1'b0, 0, 1, 0, 0},
            '{0, 2, 1'b1, 1'b1, 0, 0, 0, 0},
            '{2, 2, 1'b1, 1'b1, 0, 0, 1, 0},
            '{1, 2, 1'b1, 1'b1, 0, 0, 0, 1},
            '{0, 0, 1'b1, 1'b1, 0, 0, 0, 0},
            '{0, 1, 1'b0, 1'b0, 0, 0, 0, 0}
        };
        bus.tick_1hz = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_sel = 1'b0;
        bus.key_inc = 1'b0;
        zero_counts();
        repeat (3) step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            zero_counts();
            press(tbl[i].key);
            check($sformatf("vec%0d.mode", i), 32'(bus.mode), 32'(tbl[i].mode));
            check($sformatf("vec%0d.field", i), 32'(bus.field_sel), 32'(tbl[i].field));
            check($sformatf("vec%0d.run_en", i), 32'(bus.run_en), 32'(tbl[i].run_en));
            check($sformatf("vec%0d.inc_min", i), 32'(c_min), 32'(tbl[i].n_min));
            check($sformatf("vec%0d.inc_hour", i), 32'(c_hour), 32'(tbl[i].n_hour));
            check($sformatf("vec%0d.sw_toggle", i), 32'(c_tog), 32'(tbl[i].n_tog));
            check($sformatf("vec%0d.sw_clear", i), 32'(c_clr), 32'(tbl[i].n_clr));
        end

        // Glitch shorter than the debounce window
        zero_counts();
        bus.key_inc = 1'b1;
        repeat (3) step();
        bus.key_inc = 1'b0;
        repeat (15) step();
        check("glitch.pulses", 32'(c_min + c_hour), 0);
        check("glitch.mode", 32'(bus.mode), 1);

        // Mode sequence from reset
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            press(0);
            check($sformatf("modeseq%0d", i), 32'(bus.mode), 32'((i + 1) % 3));
        end

        // Hour auto-repeat timing relative to the raw edge
        press(1);
        check("rpt.field", 32'(bus.field_sel), 1);
        zero_counts();
        bus.key_inc = 1'b1;
        c0 = cyc;
        repeat (38) step();
        bus.key_inc = 1'b0;
        repeat (30) step();
        check("rpt.count", 32'(hour_q.size()), 5);
        check("rpt.inc_min", 32'(c_min), 0);
        for (int i = 0; i < 5; i++)
            check($sformatf("rpt.pulse%0d", i), 32'(i < hour_q.size() ? hour_q[i] - c0 : -1),
                  32'(i == 0 ? DEB + 4 : DEB + 4 + RD + (i - 1) * RR));

        // SET timeout after TIMEOUT_S idle ticks
        check("to.blink0", 32'(bus.blink), 1);
        for (int t = 1; t <= 3; t++) begin
            bus.tick_1hz = 1'b1;
            step();
            bus.tick_1hz = 1'b0;
            check($sformatf("to.mode%0d", t), 32'(bus.mode), t == 3 ? 0 : 1);
            check($sformatf("to.blink%0d", t), 32'(bus.blink), t == 1 ? 0 : 1);
            repeat (3) step();
        end

        // Simultaneous mode and inc press in SET
        press(0);
        check("simul.pre", 32'(bus.mode), 1);
        zero_counts();
        bus.key_mode = 1'b1;
        bus.key_inc = 1'b1;
        repeat (12) step();
        bus.key_mode = 1'b0;
        bus.key_inc = 1'b0;
        repeat (12) step();
        check("simul.mode", 32'(bus.mode), 2);
        check("simul.pulses", 32'(c_min + c_hour + c_tog), 0);

        // Reset in the middle of auto-repeat
        press(0);
        press(0);
        zero_counts();
        bus.key_inc = 1'b1;
        repeat (32) step();
        check("rstrpt.before", 32'(c_min), 2);
        rst = 1'b1;
        #1;
        check_reset_vals("rstrpt");
        repeat (2) step();
        rst = 1'b0;
        zero_counts();
        repeat (DEB + 2) step();
        check("rstrpt.after", 32'(c_min + c_hour + c_tog + c_clr), 0);
        check("rstrpt.mode", 32'(bus.mode), 0);
        bus.key_inc = 1'b0;

        // Randomized run against the model
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        rk = '0;
        for (int k = 0; k < 3; k++) cd[k] = int'($urandom_range(5, 40));
        chk_en = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (cd[k] == 0) begin
                    rk[k] = ~rk[k];
                    set_key(k, rk[k]);
                    if (k == 0) cd[k] = int'(rk[k] ? $urandom_range(1, 12) : $urandom_range(30, 200));
                    else if (k == 1) cd[k] = int'(rk[k] ? $urandom_range(1, 12) : $urandom_range(10, 80));
                    else cd[k] = int'(rk[k] ? $urandom_range(1, 70) : $urandom_range(5, 40));
                end else cd[k]--;
            end
            bus.tick_1hz = ($urandom_range(0, 11) == 0);
            step();
        end
        chk_en = 1'b0;

        check("run_en_tracks_mode", 32'(viol_run), 0);
        check("single_cycle_pulses", 32'(viol_pls), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
